eight_bit_switch_reader: RTL and testbench

Input-side counterpart of the 8-bit LED output path. It samples eight asynchronous slide switches and debounces each bit against a slow tick. It presents the stable byte on a valid/ready handshake for downstream logic, such as the LED driver's data input. It runs entirely on the system clock: the slow rate is a one-cycle enable tick, not a derived clock.

---
 rtl/switch_reader_pkg.sv | 8 +
 rtl/switch_tick_gen.sv | 31 +++
 rtl/eight_bit_switch_reader.sv | 84 ++++++++
 tb/tb_eight_bit_switch_reader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/switch_reader_pkg.sv
// Shared constants for the switch reader and the LED driver byte path.
package switch_reader_pkg;

  localparam int unsigned NUM_SW           = 8;
  localparam int unsigned DEF_TICK_DIV     = 100_000;
  localparam int unsigned DEF_STABLE_TICKS = 10;

endpackage

// File: rtl/switch_tick_gen.sv
// Debounce prescaler: one-cycle Tick every TICK_DIV clocks while enabled.
module switch_tick_gen
  import switch_reader_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic Clk,
  input  logic Rst,
  input  logic En,
  output logic Tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Phase is held at zero while disabled so a re-enable starts a full period.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count <= '0;
    end else if (!En || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign Tick = En && (count == LAST);

endmodule

// File: rtl/eight_bit_switch_reader.sv
// Synchronizes and debounces eight switches, presenting the stable byte on a
// valid/ready handshake with a sticky overrun flag.
module eight_bit_switch_reader
  import switch_reader_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  input  logic [NUM_SW-1:0] SwIn,
  output logic [NUM_SW-1:0] DataOut,
  output logic              DataValid,
  input  logic              DataReady,
  output logic              Overrun
);

  localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_TICKS - 1);

  logic [NUM_SW-1:0] sync_meta;
  logic [NUM_SW-1:0] sync;
  logic [NUM_SW-1:0] commit;
  logic              tick;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= SwIn;
      sync      <= sync_meta;
    end
  end

  switch_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .Clk (Clk),
    .Rst (Rst),
    .En  (En),
    .Tick(tick)
  );

  for (genvar g = 0; g < NUM_SW; g++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             differs;

    assign differs   = sync[g] != DataOut[g];
    assign commit[g] = En && tick && differs && (cnt == LAST_CNT);

    // Any cycle that agrees with the committed level discards progress.
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        cnt <= '0;
      end else if (!En || !differs) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  // A commit in the same cycle as acceptance replaces the accepted byte cleanly.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      DataOut   <= '0;
      DataValid <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      DataOut <= (DataOut & ~commit) | (sync & commit);
      if (|commit) begin
        DataValid <= 1'b1;
        if (DataValid && !DataReady) begin
          Overrun <= 1'b1;
        end
      end else if (DataValid && DataReady) begin
        DataValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eight_bit_switch_reader.sv
// Scoreboard bench for eight_bit_switch_reader with TICK_DIV=4, STABLE_TICKS=3.
module tb_eight_bit_switch_reader;

  typedef struct {
    logic [7:0] data;
    logic       ovr;
    int         lo;
    int         hi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [7:0] sw = 8'h00;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b0;
  logic       overrun;

  exp_t       q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic       prev_v = 1'b0;
  logic [7:0] prev_d = 8'h00;

  eight_bit_switch_reader #(
    .TICK_DIV    (4),
    .STABLE_TICKS(3)
  ) dut (
    .Clk      (clk),
    .Rst      (rst),
    .En       (en),
    .SwIn     (sw),
    .DataOut  (data_out),
    .DataValid(data_valid),
    .DataReady(data_ready),
    .Overrun  (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every newly presented byte must match the head of the queue.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
      prev_d = 8'h00;
    end else begin
      if (data_valid && (!prev_v || data_out != prev_d)) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: got byte %02h with no byte expected (cycle %0d)", data_out, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("event_byte", 32'(data_out), 32'(e.data));
          check("event_overrun", 32'(overrun), 32'(e.ovr));
          vectors++;
          if (cyc < e.lo || cyc > e.hi) begin
            miscompares++;
            $display("FAIL event_latency: got cycle %0d, expected %0d..%0d", cyc, e.lo, e.hi);
          end
        end
      end
      prev_v = data_valid;
      prev_d = data_out;
    end
  end

  task automatic expect_byte(input logic [7:0] d, input logic o, input int lo, input int hi);
    exp_t e;
    e.data = d;
    e.ovr  = o;
    e.lo   = cyc + lo;
    e.hi   = cyc + hi;
    q.push_back(e);
  endtask

  // Asynchronous mid-cycle pulse; returns just after release with cyc = release cycle.
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset_data", 32'(data_out), 32'h00);
    check("reset_valid", 32'(data_valid), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    #4 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d bytes pending, expected 0", name, q.size());
      q.delete();
    end
    #1;
  endtask

  task automatic accept();
    @(posedge clk);
    #1 data_ready = 1'b1;
    @(posedge clk);
    #1 data_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Clean change and single-cycle acceptance.
    do_reset();
    sw = 8'hA5;
    expect_byte(8'hA5, 1'b0, 11, 14);
    drain("clean");
    accept();
    check("clean_valid_after_accept", 32'(data_valid), 32'h0);
    check("clean_data_after_accept", 32'(data_out), 32'hA5);

    // Bounce shorter than the debounce window is rejected.
    do_reset();
    sw = 8'h00;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (i % 3 == 0) sw[0] = ~sw[0];
    end
    sw = 8'h00;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("bounce_valid", 32'(data_valid), 32'h0);
    check("bounce_data", 32'(data_out), 32'h00);

    // Overwrite of an unaccepted byte sets sticky Overrun.
    do_reset();
    sw = 8'h01;
    expect_byte(8'h01, 1'b0, 11, 14);
    drain("overrun_first");
    @(posedge clk);
    #1 sw = 8'h03;
    expect_byte(8'h03, 1'b1, 11, 14);
    drain("overrun_second");
    accept();
    check("overrun_valid_after_accept", 32'(data_valid), 32'h0);
    check("overrun_sticky", 32'(overrun), 32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("overrun_still_sticky", 32'(overrun), 32'h1);

    // Enable gating freezes debounce; re-enable starts a fresh window.
    do_reset();
    en = 1'b0;
    sw = 8'hFF;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("disabled_valid", 32'(data_valid), 32'h0);
    check("disabled_data", 32'(data_out), 32'h00);
    @(posedge clk);
    #1 en = 1'b1;
    expect_byte(8'hFF, 1'b0, 9, 14);
    drain("enable");
    accept();

    // Reset mid-debounce discards progress.
    do_reset();
    sw = 8'hF0;
    repeat (9) @(posedge clk);
    do_reset();
    expect_byte(8'hF0, 1'b0, 9, 14);
    drain("reset_mid");
    accept();
    check("reset_mid_final_data", 32'(data_out), 32'hF0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
